// File: rtl/block_dropper.sv
// Falling-block controller: spawns a block at a clamped random x and drops it on each frame tick
// until it reaches the stack top. Define DROP_ACCEL_EN to make the fall speed ramp up to 15.
module block_dropper #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned BLOCK_W   = 80,
  parameter int unsigned DROP_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rnd,
  input  logic       tick,
  input  logic       spawn,
  input  logic [9:0] stack_y,
  output logic       busy,
  output logic       active,
  output logic [9:0] block_x,
  output logic [9:0] block_y,
  output logic       landed,
  output logic [9:0] land_x
);

  localparam logic [9:0] MaxX     = 10'(SCREEN_W - BLOCK_W);
  localparam logic [3:0] StepInit = 4'(DROP_STEP);

  typedef enum logic [1:0] {StIdle, StSpawn, StFall, StLand} state_e;

  state_e      state_q, state_d;
  logic [9:0]  rnd_q, rnd_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [9:0]  land_x_q, land_x_d;
  logic        busy_q, busy_d;
  logic        active_q, active_d;
  logic        landed_q, landed_d;
  logic [10:0] next_y;

`ifdef DROP_ACCEL_EN
  logic [3:0] step_q, step_d;
`else
  logic [3:0] step_q;
  assign step_q = StepInit;
`endif

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    x_d      = x_q;
    y_d      = y_q;
    land_x_d = land_x_q;
`ifdef DROP_ACCEL_EN
    step_d   = step_q;
`endif
    // 11-bit sum so a step past y=1023 still compares correctly against the stack
    next_y   = {1'b0, y_q} + {7'd0, step_q};

    unique case (state_q)
      StIdle: begin
        if (spawn) begin
          rnd_d   = rnd;
          state_d = StSpawn;
        end
      end
      StSpawn: begin
        x_d     = (rnd_q > MaxX) ? MaxX : rnd_q;
        y_d     = 10'd0;
`ifdef DROP_ACCEL_EN
        step_d  = StepInit;
`endif
        state_d = StFall;
      end
      StFall: begin
        if (tick) begin
          if (next_y >= {1'b0, stack_y}) begin
            y_d      = stack_y;
            land_x_d = x_q;
            state_d  = StLand;
          end else begin
            y_d = next_y[9:0];
          end
`ifdef DROP_ACCEL_EN
          step_d = (step_q == 4'd15) ? step_q : step_q + 4'd1;
`endif
        end
      end
      StLand: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d   = (state_d != StIdle);
    active_d = (state_d == StSpawn) || (state_d == StFall);
    landed_d = (state_d == StLand);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      rnd_q    <= 10'd0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      land_x_q <= 10'd0;
      busy_q   <= 1'b0;
      active_q <= 1'b0;
      landed_q <= 1'b0;
`ifdef DROP_ACCEL_EN
      step_q   <= StepInit;
`endif
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      land_x_q <= land_x_d;
      busy_q   <= busy_d;
      active_q <= active_d;
      landed_q <= landed_d;
`ifdef DROP_ACCEL_EN
      step_q   <= step_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign active  = active_q;
  assign block_x = x_q;
  assign block_y = y_q;
  assign landed  = landed_q;
  assign land_x  = land_x_q;

endmodule

// File: doc/block_dropper.md
BLOCK_DROPPER -- requirements
Module: block_dropper

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, playfield width in pixels.
REQ-002 SHALL have parameter BLOCK_W, default 80, falling block width in pixels; legal range 1..SCREEN_W.
REQ-003 SHALL have parameter DROP_STEP, default 4, pixels fallen per tick; legal range 1..15.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, synchronous, active-low.
REQ-006 SHALL have port rnd  input  10  random x from the upstream LFSR stage, 0..639.
REQ-007 SHALL have port tick  input  1  frame strobe, one-cycle pulse.
REQ-008 SHALL have port spawn  input  1  request for a new block.
REQ-009 SHALL have port stack_y  input  10  landing y, the top of the stack, 0 = screen top.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port active  output  1  block visible, high in SPAWN and FALL.
REQ-012 SHALL have port block_x  output  10  left edge of the falling block.
REQ-013 SHALL have port block_y  output  10  top edge of the falling block.
REQ-014 SHALL have port landed  output  1  one-cycle pulse on landing.
REQ-015 SHALL have port land_x  output  10  block_x at the last landing, held until the next landing.

Function
REQ-016 SHALL implement the FSM IDLE -> SPAWN -> FALL -> LAND -> IDLE, with all outputs registered.
REQ-017 In IDLE, spawn=1 SHALL capture rnd in the same cycle and move to SPAWN; spawn SHALL be ignored in every other state.
REQ-018 SPAWN SHALL set block_x = min(captured rnd, SCREEN_W-BLOCK_W), set block_y = 0, and move to FALL on the next cycle unconditionally (1 cycle).
REQ-019 In FALL, each tick SHALL compute next = block_y + step at 11 bits; if next >= stack_y, then block_y = stack_y and the FSM moves to LAND; else block_y = next.
REQ-020 In FALL, block_y SHALL hold when tick=0; stack_y SHALL be read live on each tick and never latched.
REQ-021 LAND SHALL last exactly 1 cycle: landed=1, land_x=block_x, active=0, and the FSM moves to IDLE.
REQ-022 stack_y=0 SHALL cause a landing on the first FALL tick, with block_y=0.
REQ-023 In IDLE, tick SHALL have no effect; spawn and tick in the same IDLE cycle SHALL count as a spawn only.
REQ-024 Spawn-to-first-move latency SHALL be 2 cycles plus the wait for the next tick.
REQ-025 block_x and block_y SHALL hold their last values in IDLE.

Reset
REQ-026 rst=0 at a clock edge SHALL force IDLE, busy=0, active=0, landed=0, block_x=0, block_y=0, land_x=0, and step=DROP_STEP.
REQ-027 Reset mid-FALL SHALL abandon the block; landed SHALL NOT pulse on reset.
REQ-028 spawn SHALL be ignored in any cycle with rst=0.

Configuration
REQ-029 With macro DROP_ACCEL_EN defined, step SHALL start at DROP_STEP in SPAWN and increase by 1 after each FALL tick, saturating at 15.
REQ-030 Without DROP_ACCEL_EN, step SHALL be the constant DROP_STEP and the increment logic SHALL be absent.

Verification
REQ-031 Reset, then spawn with rnd=100 and stack_y=400 -> block_x=100; block_y reaches 400 after 100 ticks; landed pulses 1 cycle; land_x=100.
REQ-032 rnd=600 with defaults -> block_x=560 (clamped); rnd=560 -> 560; rnd=559 -> 559.
REQ-033 stack_y=10 with DROP_STEP=4 -> block_y 4, 8, then 10 on the third tick, followed by LAND.
REQ-034 spawn pulsed during FALL -> ignored: block_x unchanged and no second landing.
REQ-035 rst=0 asserted at block_y=40 in FALL -> next cycle is IDLE, all outputs 0, no landed pulse.
REQ-036 DROP_ACCEL_EN with stack_y=400 -> successive block_y values are 4, 9, 15, 22, ...; step holds at 15 after 11 ticks.
